// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame width, baud divider helpers.
// Used by uart_receiver and the matching transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

  // Bits needed to hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter, tick is combinational at DIV-1.
// Latency: first tick DIV cycles after restart; no backpressure (pulse output only).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int RAW_DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DIV     = (RAW_DIV < 1) ? 1 : RAW_DIV;
  localparam int CW      = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 2-FF rxd sync, 3-sample majority vote; UART_RX_PARITY_EN adds even parity (8E1).
// Byte lands on data one cycle after the stop-bit vote; no backpressure: an unread byte is overwritten and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = cnt_width(OVERSAMPLE);
  localparam int IW = cnt_width(DATA_BITS);
  localparam logic [TW-1:0] S_A     = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] S_B     = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] S_C     = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] OS_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);

  uart_state_t state_q, state_d;

  logic rxd_meta, rxd_s, rxd_prev;
  logic fall, tick, restart;
  logic [TW-1:0] tick_cnt;
  logic samp_a, samp_b, vote, vote_stb;
  logic [IW-1:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic good_frame, bad_frame;

  // Idle-high reset values keep a reset release from looking like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  assign fall = rxd_prev & ~rxd_s;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  assign vote     = (samp_a & samp_b) | (samp_a & rxd_s) | (samp_b & rxd_s);
  assign vote_stb = tick && (tick_cnt == S_C) &&
                    (state_q != IDLE) && (state_q != BREAK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err;

  // Sticky for the frame; cleared when a new start bit is confirmed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err <= 1'b0;
    end else if (vote_stb && state_q == START) begin
      par_err <= 1'b0;
    end else if (vote_stb && state_q == PARITY) begin
      par_err <= vote ^ (^shreg);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    restart    = 1'b0;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          restart = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (vote_stb) state_d = vote ? IDLE : DATA;
      end
      DATA: begin
        if (vote_stb && bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (vote_stb) state_d = STOP;
      end
`endif
      STOP: begin
        if (vote_stb) begin
          if (!vote) begin
            bad_frame = 1'b1;
            state_d   = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err) begin
            bad_frame = 1'b1;
            state_d   = IDLE;
`endif
          end else begin
            good_frame = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      BREAK: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tick position within the bit wraps freely, so votes recur every OVERSAMPLE ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      if (restart) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= (tick_cnt == OS_LAST) ? '0 : tick_cnt + TW'(1);
      end
      if (tick && tick_cnt == S_A) samp_a <= rxd_s;
      if (tick && tick_cnt == S_B) samp_b <= rxd_s;
      if (vote_stb) begin
        case (state_q)
          START: bit_idx <= '0;
          DATA: begin
            shreg   <= {vote, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_frame;
      overrun   <= good_frame & valid & ~rd;
      if (good_frame) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (rd) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: each frame pushes its expected outcome, the monitor pops on valid/overrun/frame_err.
module tb_uart_receiver;

  localparam int BIT_CLK = 160;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAT_MIN = (FRAME_BITS - 1) * BIT_CLK + 40;
  localparam int LAT_MAX = FRAME_BITS * BIT_CLK;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rd  = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  uart_receiver #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rd       (rd),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_done   = 0;
  int   n_ferr   = 0;
  int   n_ovr    = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   rise_cyc  = 0;
  logic valid_q  = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (frame_err || overrun) check("pulse_excl", {31'd0, frame_err & overrun}, 32'd0);
      if (frame_err) begin
        n_ferr++;
        check("sb_has_err", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check("exp_err_frame", {31'd0, mon_e.err}, 32'd1);
        end
      end
      if (overrun) n_ovr++;
      if ((valid && !valid_q) || overrun) begin
        n_done++;
        if (valid && !valid_q) rise_cyc = cyc;
        check("sb_has_good", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check("exp_good_frame", {31'd0, mon_e.err}, 32'd0);
          check("rx_data", {24'd0, data}, {24'd0, mon_e.b});
        end
      end
    end
    valid_q = valid;
  end

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic expect_err);
    sb_q.push_back({expect_err, b});
    start_cyc = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^b) ^ par_flip);
`endif
    bit_time(stop_v);
  endtask

  task automatic read_byte();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  int k_ferr, k_done;

  initial begin
    repeat (5) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // single byte, latency and rd handshake
    rise_cyc = 0;
    send_frame(8'hA5, 1'b1, 1'b0);
    check("t1_latency_ok", {31'd0, (rise_cyc - start_cyc >= LAT_MIN) && (rise_cyc - start_cyc <= LAT_MAX)}, 32'd1);
    check("t1_valid", {31'd0, valid}, 32'd1);
    check("t1_data", {24'd0, data}, 32'h0000_00A5);
    check("t1_ferr_cnt", n_ferr, 32'd0);
    read_byte();
    check("t1_rd_clears", {31'd0, valid}, 32'd0);

    // back-to-back frames without reading
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("t2_valid", {31'd0, valid}, 32'd1);
    check("t2_data", {24'd0, data}, 32'h0000_00C3);
    check("t2_overrun_cnt", n_ovr, 32'd1);
    read_byte();

    // stop bit low followed by a held-low line
    k_ferr = n_ferr;
    k_done = n_done;
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (500) @(negedge clk);
    check("t3_ferr_cnt", n_ferr, k_ferr + 1);
    check("t3_valid", {31'd0, valid}, 32'd0);
    rxd = 1'b1;
    repeat (400) @(negedge clk);
    check("t3_no_frame", n_done, k_done);
    check("t3_ferr_once", n_ferr, k_ferr + 1);

    // short glitch is rejected, then a normal frame still decodes
    k_ferr = n_ferr;
    k_done = n_done;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (400) @(negedge clk);
    check("t4_valid", {31'd0, valid}, 32'd0);
    check("t4_no_ferr", n_ferr, k_ferr);
    check("t4_no_frame", n_done, k_done);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("t4_data", {24'd0, data}, 32'h0000_005A);
    check("t4_valid_after", {31'd0, valid}, 32'd1);

    // reset in the middle of bit 4 of 8'hFF
    k_done = n_done;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rxd = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rst_data", {24'd0, data}, 32'd0);
    check("t5_rst_valid", {31'd0, valid}, 32'd0);
    check("t5_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("t5_rst_ovr", {31'd0, overrun}, 32'd0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat ((FRAME_BITS - 5) * BIT_CLK) @(negedge clk);
    check("t5_no_frame", n_done, k_done);
    send_frame(8'h81, 1'b1, 1'b0);
    check("t5_data", {24'd0, data}, 32'h0000_0081);
    check("t5_valid", {31'd0, valid}, 32'd1);
    read_byte();

`ifdef UART_RX_PARITY_EN
    k_ferr = n_ferr;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_par_ferr", n_ferr, k_ferr + 1);
    check("t6_par_valid", {31'd0, valid}, 32'd0);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0);
    check("t6_data", {24'd0, data}, 32'h0000_0007);
    check("t6_valid", {31'd0, valid}, 32'd1);
`endif

    repeat (50) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    check("final_ovr_cnt", n_ovr, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1);
  end

endmodule
